// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub
//
// W-bit add/subtract (W = 4*NIBBLES) computed by time-sharing a single 4-bit
// ripple-carry adder over NIBBLES consecutive cycles, least-significant
// nibble first. The inter-nibble carry lives in carry_q between cycles.
//
// Handshake: start is a single-cycle request. It is accepted on a rising edge
// only while the controller is IDLE or DONE. In RUN it is ignored, and no
// request is queued. op/a/b matter only in the accepting cycle. Completion is
// signalled by a one-cycle done pulse. result/cout/ovf become valid in that
// same cycle and hold until the next completion or reset.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  operation request (accepted in IDLE or DONE)
//   op     0 = A+B, 1 = A-B (sampled with start)
//   a, b   W-bit operands (sampled with start)
//   busy   high while nibbles are being processed (RUN)
//   done   one-cycle completion pulse
//   result W-bit sum/difference, modulo 2^W
//   cout   final carry out (subtract: 1 = no borrow)
//   ovf    two's-complement signed overflow

// 4-bit ripple-carry adder slice (A, B, CI -> S, CO).
module nibble_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          op_q;
  logic          carry_q;
  logic [IW-1:0] idx;
  logic [W-1:0]  acc;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    nib_s;
  logic          nib_co;
  logic [W-1:0]  acc_next;
  logic          last_nib;
  logic          ovf_next;

  // Subtraction is A + ~B + 1: B is inverted here and the +1 is injected
  // through carry_q when the operation is accepted.
  always_comb begin
    nib_a = a_q[4*idx +: 4];
    nib_b = b_q[4*idx +: 4] ^ {4{op_q}};
  end

  nibble_rca4 u_rca (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  // acc with the current nibble merged in, so the final result can be
  // registered on the same edge that writes the last nibble.
  always_comb begin
    acc_next = acc;
    acc_next[4*idx +: 4] = nib_s;
  end

  assign last_nib = (idx == IW'(NIBBLES - 1));

  // Signed overflow from the latched operand MSBs and the result MSB, which
  // is the top bit of the last nibble sum.
  always_comb begin
    if (op_q) ovf_next = (a_q[W-1] != b_q[W-1]) && (nib_s[3] != a_q[W-1]);
    else      ovf_next = (a_q[W-1] == b_q[W-1]) && (nib_s[3] != a_q[W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      idx     <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= op;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end else begin
            state   <= S_IDLE;
          end
        end
        S_RUN: begin
          acc     <= acc_next;
          carry_q <= nib_co;
          if (last_nib) begin
            result <= acc_next;
            cout   <= nib_co;
            ovf    <= ovf_next;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle controller that performs W-bit add/subtract (W = 4·NIBBLES) by time-sharing one 4-bit ripple-carry adder over NIBBLES consecutive cycles.
- Operands are latched on a start handshake.
- The adder is sequenced least-significant nibble first, with the inter-nibble carry held in a register.
- The finished result and flags are presented with a one-cycle done pulse.
- The block sits between the team's 4-bit adder datapath and any requester that needs wider arithmetic without replicating adders.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (W = 4·NIBBLES); legal range 2..8

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE or DONE
- op  input  1  0 = add (A+B), 1 = subtract (A−B); sampled with start
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result/flags valid from this cycle on
- result  output  W  sum/difference, held until the next completion
- cout  output  1  final carry out; for subtract, 1 = no borrow
- ovf  output  1  two's-complement signed overflow

## Operation
Datapath:
- One instance of the team's 4-bit ripple-carry adder (A, B, CI, S, CO).
- Adder inputs, per nibble index idx:
  - A nibble = a_q[4·idx+3 : 4·idx].
  - B nibble = b_q nibble, XOR'd with {4{op_q}}.
  - CI = carry_q.

FSM states and transitions:
- IDLE → RUN on start. On acceptance:
  - a_q ← a, b_q ← b, op_q ← op.
  - carry_q ← op (subtract injects +1).
  - idx ← 0.
- RUN: each cycle, S is written into acc nibble idx and carry_q ← CO.
  - idx increments while idx < NIBBLES−1.
  - When idx = NIBBLES−1, go to DONE.
- DONE (exactly one cycle): done = 1.
  - result ← completed acc, cout ← final CO, ovf computed (see below).
  - start in DONE → RUN, identical to acceptance from IDLE (back-to-back operation).
  - Otherwise → IDLE.

Handshake rules:
- start in RUN is ignored; no queuing, latched operands are unaffected.
- a, b, op are don't-care except in the acceptance cycle.

Overflow rule (on latched operand MSBs and result MSB):
- add: ovf = (a_msb == b_msb) && (res_msb != a_msb).
- sub: ovf = (a_msb != b_msb) && (res_msb != a_msb).

Width rule:
- result is W bits, modulo 2^W; no saturation.
- idx is ceil(log2 NIBBLES) bits and never exceeds NIBBLES−1.

Reset (asynchronous, any state including mid-RUN):
- State → IDLE; internal registers cleared.
- busy, done, result, cout, ovf = 0.
- The aborted operation produces no done.

## Timing
- Start sampled high at rising edge E0 (IDLE or DONE).
- busy is high during cycles after E0 through E0+NIBBLES.
- The last nibble is written at edge E0+NIBBLES.
- done = 1 and result/cout/ovf update on the cycle after edge E0+NIBBLES; latency is NIBBLES+1 edges.
- busy = 0 in the DONE cycle.
- Back-to-back: start during the done cycle yields a throughput of one operation per NIBBLES+1 cycles.
- result/cout/ovf change only on entry to DONE (or on reset); they never show partial values.
- The adder is combinational within a cycle; no extra pipeline stage.

## Test plan
- Add: NIBBLES=4, op=0, a=0x1234, b=0x4321 → done 5 edges after start, result=0x5555, cout=0, ovf=0; busy high for exactly 4 cycles.
- Add carry/overflow cases:
  - 0xFFFF+0x0001 → result=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → result=0x8000, cout=0, ovf=1.
- Subtract cases:
  - 0x0005−0x0007 → result=0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → result=0x7FFF, cout=1, ovf=1.
- Protocol:
  - start re-asserted with different operands on every RUN cycle → ignored; first operation's result is unchanged.
  - start held during DONE → second operation starts immediately; its done arrives 5 cycles after the first done.
- Reset: assert rst asynchronously two cycles into a RUN (between edges) → busy/done/result/cout/ovf go to 0 immediately, no done pulse follows; a fresh operation after release completes correctly.
- Parameter: NIBBLES=2, 0xFF+0x01 → result=0x00, cout=1, done 3 edges after start.
